instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the decode controller.
- Keeps the PC and issues in-order word requests to instruction memory over a valid/ready request and valid response interface.
- Buffers returned instructions in a small FIFO and presents the head instruction to the controller, with the opcode/func3/func7 fields pre-split.
- Handles control-flow redirects from branch/jump resolution: flushes the buffer and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- DEPTH, 2, instruction buffer entries (power of two, ≥2); also bounds outstanding requests.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response valid; responses return in request order, latency ≥1 cycle.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch taken / jump (one-cycle pulse).
- redirect_pc  in  32  redirect target.
- instr_valid  out  1  buffer head valid.
- instr_ready  in  1  downstream consumes head.
- instr  out  32  head instruction.
- instr_pc  out  32  PC of head instruction.
- opcode  out  7  instr[6:0].
- func3  out  3  instr[14:12].
- func7  out  7  instr[31:25].

Interface rule: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, asynchronous):
  - fetch_pc = RESET_PC; FIFO empty; outstanding count = 0; state = RUN.
  - imem_req_valid = 0, instr_valid = 0.
  - instr, instr_pc, opcode, func3, func7 = 0.
- First request is presented in the first clock edge after rst_n rises.
- Credit: request issued only when state == RUN and occupancy + outstanding < DEPTH.
  - imem_req_addr = fetch_pc.
  - On imem_req_valid & imem_req_ready: fetch_pc += 4 (wraps modulo 2^32); outstanding += 1.
- imem_req_valid, once asserted, holds with a stable address until accepted, unless a redirect occurs.
- Response: on imem_rsp_valid in RUN, push {pc, data} and decrement outstanding.
  - Pushed PC is tracked by a response-PC register that advances by 4 per response.
  - The credit rule guarantees the FIFO is never full on a push.
- Output: instr_valid = FIFO not empty. Head pops on instr_valid & instr_ready.
  - Outputs are held stable while instr_valid & !instr_ready.
  - Field outputs are slices of the head instruction; their value is don't-care when instr_valid = 0.
- Simultaneous push and pop keep occupancy unchanged; a pop from 1 entry with a same-cycle push yields 1 entry.
- Redirect (highest priority, same edge):
  - FIFO flushed; any same-cycle pop and push are ignored.
  - fetch_pc and response-PC = redirect_pc.
  - A request accepted in the redirect cycle counts as stale.
  - If outstanding after this edge > 0 → DRAIN, else stay RUN.
- DRAIN state:
  - No requests issued; each response is discarded and decrements outstanding.
  - Move to RUN when outstanding reaches 0 (the edge of the last discard). The first new request is presented the next cycle.
  - A redirect in DRAIN updates fetch_pc and stays in DRAIN.
- instr_valid is 0 in the cycle after a redirect.
- Reset mid-transaction: all state is cleared. Responses arriving after reset deasserts for pre-reset requests are out of contract.

Optional Feature:
- IFU_MISALIGN_CHK_EN defined:
  - Adds output fetch_misaligned (1 bit, reset 0), set on a redirect with redirect_pc[1:0] != 0.
  - While set, requests are blocked and fetch_pc is held.
  - Cleared only by a subsequent aligned redirect.
- Not defined:
  - Port absent; redirect_pc[1:0] is forced to 2'b00.

Decomposition:
- Package ifu_pkg holds:
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
  - ifu_state_e enum {RUN, DRAIN}.
  - localparam INSTR_BYTES = 4.
  - Opcode field slice position constants.
- Sub-module ifu_fifo (DEPTH-entry synchronous FIFO of fetch_entry_t with flush input).
- Top module holds the PC, credit counter and FSM.

Test Plan:
- Reset, then zero-wait memory (ready = 1, 1-cycle latency), instr_ready = 1 → requests to 0x0, 0x4, 0x8…; instr_pc follows the same sequence. For response 0x00500093, opcode = 0x13, func3 = 0, func7 = 0.
- instr_ready = 0 for 6 cycles → at most DEPTH = 2 requests; FIFO holds 0x0 and 0x4 stable; no request until a pop.
- Redirect to 0x100 with 2 outstanding requests → DRAIN; both responses dropped; next instr_pc = 0x100; no instruction from 0x8 or 0xC ever presented.
- Redirect in the same cycle as a pop and a response push → FIFO empty next cycle; pushed data discarded.
- imem_req_ready low for 3 cycles → address held at 0x8; fetch_pc advances only on acceptance.
- Misalign (with IFU_MISALIGN_CHK_EN): redirect to 0x102 → fetch_misaligned = 1, no requests; redirect to 0x200 → cleared, fetch resumes at 0x200.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_entry_t : buffered {pc, instr} pair
//   ifu_state_e   : RUN (fetching) / DRAIN (discarding stale responses)
//   INSTR_BYTES   : PC increment per fetched word
//   *_LSB/*_MSB   : instruction field slice positions
package ifu_pkg;

  localparam int INSTR_BYTES = 4;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNC3_LSB  = 12;
  localparam int FUNC3_MSB  = 14;
  localparam int FUNC7_LSB  = 25;
  localparam int FUNC7_MSB  = 31;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ifu_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// DEPTH-entry synchronous FIFO of fetch_entry_t with a flush input.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO; overrides push and pop in the same cycle
//   push/wdata : write an entry (caller guarantees not full)
//   pop        : remove the head entry (caller guarantees not empty)
//   rdata      : head entry (all-zero after reset)
//   empty      : no entries held
//   count      : current occupancy (0..DEPTH)
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t rdata,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is reset so the head (and the field outputs derived from it)
  // reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues in-order word requests to
// instruction memory under a credit limit of DEPTH, buffers responses and
// presents the head instruction with opcode/func3/func7 pre-split.
// Redirects flush the buffer; responses to pre-redirect requests are
// discarded in the DRAIN state.
// Optional build macro IFU_MISALIGN_CHK_EN adds the fetch_misaligned output
// (set by a misaligned redirect, blocks fetching until an aligned redirect).
// Without it, redirect_pc[1:0] is ignored (treated as 2'b00).
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   imem_req_valid/addr/ready       : memory request channel
//   imem_rsp_valid/data             : in-order memory responses
//   redirect_valid/pc               : control-flow redirect pulse and target
//   instr_valid/ready, instr, instr_pc : head of the instruction buffer
//   opcode, func3, func7            : fields of the head instruction
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_e    state;
  ifu_state_e    state_d;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   redir_target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_d;
  logic [CW-1:0] occ;
  logic [CW-1:0] occ_d;
  logic [CW:0]   credit_used;
  logic          accept;
  logic          push;
  logic          pop;
  logic          block_d;
  logic          req_valid_d;
  logic          fifo_empty;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

`ifdef IFU_MISALIGN_CHK_EN
  logic misaligned_d;

  assign redir_target = redirect_pc;
  assign misaligned_d = redirect_valid ? (redirect_pc[1:0] != 2'b00) : fetch_misaligned;
  assign block_d      = misaligned_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_misaligned <= 1'b0;
    end else begin
      fetch_misaligned <= misaligned_d;
    end
  end
`else
  logic [1:0] unused_redirect_low;

  assign unused_redirect_low = redirect_pc[1:0];
  assign redir_target        = {redirect_pc[31:2], 2'b00};
  assign block_d             = 1'b0;
`endif

  assign accept = imem_req_valid & imem_req_ready;
  // A redirect overrides any same-cycle push or pop.
  assign push   = imem_rsp_valid & (state == RUN) & ~redirect_valid;
  assign pop    = instr_valid & instr_ready & ~redirect_valid;

  // Every response retires one outstanding request, whether kept or dropped.
  assign out_d = outstanding + CW'(accept) - CW'(imem_rsp_valid);
  assign occ_d = redirect_valid ? '0 : (occ + CW'(push) - CW'(pop));

  always_comb begin
    state_d = state;
    if (redirect_valid) begin
      state_d = (out_d != '0) ? DRAIN : RUN;
    end else if ((state == DRAIN) && (out_d == '0)) begin
      state_d = RUN;
    end
  end

  // The request valid is registered from next-cycle occupancy and credit, so
  // it evaluates the credit rule on the state the request cycle will see.
  // An unaccepted request never loses credit (pushes only trade outstanding
  // for occupancy), so it holds until accepted or redirected.
  assign credit_used = {1'b0, occ_d} + {1'b0, out_d};
  assign req_valid_d = (state_d == RUN) & ~block_d & (credit_used < (CW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      fetch_pc       <= RESET_PC;
      rsp_pc         <= RESET_PC;
      outstanding    <= '0;
      imem_req_valid <= 1'b0;
    end else begin
      state          <= state_d;
      outstanding    <= out_d;
      imem_req_valid <= req_valid_d;
      if (redirect_valid) begin
        fetch_pc <= redir_target;
        rsp_pc   <= redir_target;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
        if (push)   rsp_pc   <= rsp_pc + 32'(INSTR_BYTES);
      end
    end
  end

  assign imem_req_addr    = fetch_pc;
  assign push_entry.pc    = rsp_pc;
  assign push_entry.instr = imem_rsp_data;

  ifu_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .count (occ)
  );

  assign instr_valid = ~fifo_empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign opcode      = head.instr[OPCODE_MSB:OPCODE_LSB];
  assign func3       = head.instr[FUNC3_MSB:FUNC3_LSB];
  assign func7       = head.instr[FUNC7_MSB:FUNC7_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A queue-based reference model
// (in-flight request list with stale marks, expected instruction buffer)
// drives a randomized memory and checks every cycle; directed sequences
// cover decode vectors, stalls, redirects, wrap and reset.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          NV       = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
`ifdef IFU_MISALIGN_CHK_EN
  logic        fetch_misaligned;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .func3          (func3),
    .func7          (func7)
`ifdef IFU_MISALIGN_CHK_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  typedef struct { logic [31:0] addr; bit stale; int cyc; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] word; logic [6:0] op; logic [2:0] f3; logic [6:0] f7; } vec_t;

  int checks = 0;
  int failures = 0;

  req_t        inflight[$];
  ent_t        buf_m[$];
  logic [31:0] next_addr;
  bit          mis_m;
  int          cyc = 0;
  int          p_ready, p_rsp, p_iready;
  bit          prev_hold;
  logic [31:0] prev_addr;
  bit          last_pop;
  logic [31:0] last_pc, last_instr;
  logic [6:0]  last_op, last_f7;
  logic [2:0]  last_f3;
  int          accepts, pops;
  bit          t5_hit;
  vec_t        vec[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Low addresses hold the decode vectors; everything else is a hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'(4 * NV)) return vec[a[4:2]].word;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] eff(input logic [31:0] t);
`ifdef IFU_MISALIGN_CHK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic check_outputs();
    int  stale_n;
    bit  exp_req;
    stale_n = 0;
    foreach (inflight[i]) if (inflight[i].stale) stale_n++;
    exp_req = (stale_n == 0) && !mis_m && ((inflight.size() + buf_m.size()) < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (imem_req_valid) chk("req_addr", imem_req_addr, next_addr);
    if (prev_hold) begin
      chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("req_hold_addr", imem_req_addr, prev_addr);
    end
    chk("instr_valid", 32'(instr_valid), 32'(buf_m.size() != 0));
    if (buf_m.size() != 0) begin
      chk("instr_pc", instr_pc, buf_m[0].pc);
      chk("instr", instr, buf_m[0].data);
      chk("opcode", 32'(opcode), 32'(buf_m[0].data & 32'h7F));
      chk("func3", 32'(func3), (buf_m[0].data >> 12) & 32'h7);
      chk("func7", 32'(func7), buf_m[0].data >> 25);
    end
`ifdef IFU_MISALIGN_CHK_EN
    chk("fetch_misaligned", 32'(fetch_misaligned), 32'(mis_m));
`endif
  endtask

  // rmode: 0 = no redirect, 1 = redirect, 2 = redirect only when a pop and a
  // response push coincide in this cycle.
  task automatic step(input int rmode, input logic [31:0] tgt);
    bit          rdy, irdy, rsp, redir, acc, pp;
    logic [31:0] data;
    req_t        r;
    @(negedge clk);
    check_outputs();
    rdy  = int'($urandom_range(99)) < p_ready;
    irdy = int'($urandom_range(99)) < p_iready;
    rsp  = 1'b0;
    data = $urandom();
    if (inflight.size() > 0 && inflight[0].cyc < cyc && int'($urandom_range(99)) < p_rsp) begin
      rsp  = 1'b1;
      data = mem_word(inflight[0].addr);
    end
    acc   = imem_req_valid && rdy;
    pp    = instr_valid && irdy;
    redir = (rmode == 1) || (rmode == 2 && pp && rsp);
    if (rmode == 2 && redir) t5_hit = 1'b1;
    imem_req_ready = rdy;
    imem_rsp_valid = rsp;
    imem_rsp_data  = data;
    instr_ready    = irdy;
    redirect_valid = redir;
    redirect_pc    = redir ? tgt : $urandom();
    last_pop   = pp && !redir;
    last_pc    = instr_pc;
    last_instr = instr;
    last_op    = opcode;
    last_f3    = func3;
    last_f7    = func7;
    if (last_pop) pops++;
    if (rsp) begin
      r = inflight.pop_front();
      if (!r.stale && !redir) buf_m.push_back('{r.addr, data});
    end
    if (acc) begin
      inflight.push_back('{imem_req_addr, 1'b0, cyc});
      next_addr = next_addr + 32'd4;
      accepts++;
    end
    if (pp && !redir && buf_m.size() > 0) void'(buf_m.pop_front());
    if (redir) begin
      buf_m.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      next_addr = eff(tgt);
`ifdef IFU_MISALIGN_CHK_EN
      mis_m = (tgt[1:0] != 2'b00);
`endif
    end
    prev_hold = imem_req_valid && !rdy && !redir;
    prev_addr = imem_req_addr;
    cyc++;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_fields", {18'd0, opcode, func3, func7}, 32'd0);
`ifdef IFU_MISALIGN_CHK_EN
    chk("rst_misaligned", 32'(fetch_misaligned), 32'd0);
`endif
    inflight.delete();
    buf_m.delete();
    next_addr = RESET_PC;
    mis_m     = 1'b0;
    prev_hold = 1'b0;
    accepts   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_req_valid", 32'(imem_req_valid), 32'd0);
  endtask

  task automatic set_p(input int r, input int s, input int i);
    p_ready  = r;
    p_rsp    = s;
    p_iready = i;
  endtask

  initial begin
    int          n;
    bit          seen;
    logic [31:0] t;

    vec[0] = '{32'h0050_0093, 7'h13, 3'h0, 7'h00};
    vec[1] = '{32'h40B5_0533, 7'h33, 3'h0, 7'h20};
    vec[2] = '{32'hFFFF_FFFF, 7'h7F, 3'h7, 7'h7F};
    vec[3] = '{32'h0000_7000, 7'h00, 3'h7, 7'h00};
    vec[4] = '{32'hFE00_0000, 7'h00, 3'h0, 7'h7F};
    vec[5] = '{32'h0000_406F, 7'h6F, 3'h4, 7'h00};
    vec[6] = '{32'h1234_5678, 7'h78, 3'h5, 7'h09};
    pops   = 0;
    t5_hit = 1'b0;

    // Zero-wait fetch of the decode vectors from address 0.
    set_p(100, 100, 100);
    do_reset();
    n = 0;
    for (int k = 0; k < 80 && n < NV; k++) begin
      step(0, '0);
      if (last_pop) begin
        chk("vec_pc", last_pc, 32'(4 * n));
        chk("vec_instr", last_instr, vec[n].word);
        chk("vec_opcode", 32'(last_op), 32'(vec[n].op));
        chk("vec_func3", 32'(last_f3), 32'(vec[n].f3));
        chk("vec_func7", 32'(last_f7), 32'(vec[n].f7));
        n++;
      end
    end
    chk("vec_count", 32'(n), 32'(NV));

    // Consumer stalled: exactly DEPTH requests, head held at 0x0.
    set_p(100, 100, 0);
    do_reset();
    repeat (6) step(0, '0);
    #1;
    chk("stall_accepts", 32'(accepts), 32'(DEPTH));
    chk("stall_head_pc", instr_pc, 32'h0);
    chk("stall_no_req", 32'(imem_req_valid), 32'd0);
    p_iready = 100;
    repeat (6) step(0, '0);

    // Redirect with two requests outstanding: both responses dropped.
    set_p(100, 0, 100);
    do_reset();
    repeat (3) step(0, '0);
    chk("drain_outstanding", 32'(inflight.size()), 32'd2);
    step(1, 32'h0000_0100);
    p_rsp = 100;
    seen  = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(0, '0);
      if (last_pop) begin
        seen = 1'b1;
        chk("drain_first_pc", last_pc, 32'h0000_0100);
      end
    end
    chk("drain_resumed", 32'(seen), 32'd1);

    // Redirect coinciding with a pop and a response push.
    set_p(100, 100, 100);
    do_reset();
    for (int k = 0; k < 40 && !t5_hit; k++) step(2, 32'h0000_0040);
    chk("redir_pop_push_hit", 32'(t5_hit), 32'd1);
    repeat (4) step(0, '0);

    // Memory not ready: address 0x8 held until accepted.
    do_reset();
    for (int k = 0; k < 10 && accepts < 2; k++) step(0, '0);
    p_ready = 0;
    repeat (5) step(0, '0);
    #1;
    chk("backpressure_valid", 32'(imem_req_valid), 32'd1);
    chk("backpressure_addr", imem_req_addr, 32'h0000_0008);
    chk("backpressure_accepts", 32'(accepts), 32'd2);
    p_ready = 100;
    repeat (6) step(0, '0);

    // Address wrap past 0xFFFF_FFFC.
    step(1, 32'hFFFF_FFF8);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(0, '0);
      if (last_pop && last_pc == 32'h0) seen = 1'b1;
    end
    chk("wrap_to_zero", 32'(seen), 32'd1);

    // Randomized traffic with random redirects and a mid-run reset.
    pops = 0;
    for (int blk = 0; blk < 10; blk++) begin
      if (blk == 5) do_reset();
      set_p(int'($urandom_range(100, 20)), int'($urandom_range(100, 20)),
            int'($urandom_range(100, 10)));
      for (int k = 0; k < 200; k++) begin
        if ($urandom_range(99) < 4) begin
          case ($urandom_range(2))
            0:       t = $urandom();
            1:       t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            default: t = 32'($urandom_range(63));
          endcase
`ifdef IFU_MISALIGN_CHK_EN
          t = t & 32'hFFFF_FFFC;
`endif
          step(1, t);
        end else begin
          step(0, '0);
        end
      end
    end
    chk("random_progress", 32'(pops > 100), 32'd1);

`ifdef IFU_MISALIGN_CHK_EN
    set_p(100, 100, 100);
    do_reset();
    repeat (4) step(0, '0);
    step(1, 32'h0000_0102);
    repeat (6) step(0, '0);
    #1;
    chk("misalign_set", 32'(fetch_misaligned), 32'd1);
    chk("misalign_no_req", 32'(imem_req_valid), 32'd0);
    step(1, 32'h0000_0200);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(0, '0);
      if (last_pop) begin
        seen = 1'b1;
        chk("misalign_resume_pc", last_pc, 32'h0000_0200);
      end
    end
    chk("misalign_resumed", 32'(seen), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
